irda_sir_rx_deframer: RTL and testbench
=======================================

Name: irda_sir_rx_deframer

Overview:
- Downstream stage of the SIR pulse decoder on the receive path.
- Consumes one decoded SIR bit per bit period and recovers asynchronous character frames: start bit, DATA_BITS data bits LSB first, one stop bit.
- Presents each completed character in a single-entry holding register with a valid/ack handshake toward the Wishbone-side RX FIFO logic.
- Reports framing error, break and overrun.

Parameters:
- DATA_BITS, 8: data bits per character; legal range 5..8.

Ports:
- clk  input  1  system clock.
- wb_rst_n  input  1  synchronous, active-low reset.
- fast_mode  input  1  MIR/FIR mode active; while high the deframer is held idle.
- tx_select  input  1  transceiver is transmitting; while high, bit strobes are ignored.
- bit_stb_i  input  1  one-cycle strobe: a new decoded bit is present on rx_zero_i.
- rx_zero_i  input  1  decoded bit: 1 = pulse seen (logical 0), 0 = no pulse (logical 1).
- data_o  output  DATA_BITS  received character.
- data_valid_o  output  1  data_o holds an unacknowledged character.
- data_ack_i  input  1  consumer takes data_o; effective only while data_valid_o=1.
- frame_err_o  output  1  character in data_o had a logical-0 stop bit.
- break_o  output  1  character in data_o was all zeros with a logical-0 stop bit.
- overrun_o  output  1  sticky: a character was lost while the holding register was full.

Behaviour:
- Reset (wb_rst_n=0 at a clk edge): state=IDLE; bit counter=0; shift register=0; data_o=0; data_valid_o=0; frame_err_o=0; break_o=0; overrun_o=0.
- Bit value = ~rx_zero_i, sampled only on cycles with bit_stb_i=1, tx_select=0 and fast_mode=0.
- fast_mode=1: state forced to IDLE, bit counter and shift register cleared. Holding register and flags are untouched.
- tx_select=1 mid-frame: strobes are ignored and state is held; reception resumes on the next qualified strobe.
- State machine:
  - IDLE: a qualified strobe with bit 0 moves to DATA with bit counter=0. Bit 1 stays in IDLE.
  - DATA: each qualified strobe shifts the bit into the MSB of the shift register (right shift; LSB first on the line) and increments the counter. The strobe carrying data bit DATA_BITS-1 moves to STOP.
  - STOP: the next qualified strobe samples the stop bit, completes the character and returns to IDLE. A logical-0 stop bit is not re-used as a start bit.
- Completion, registered on the cycle after the stop-bit strobe (latency 1 clk):
  - Holding register free (data_valid_o=0), or being acked in the completion cycle: load data_o, frame_err_o=~stop, break_o=(~stop & data==0); set data_valid_o=1.
  - Holding register full and not acked: discard the new character, set overrun_o=1, keep old data_o and flags.
- Ack: data_ack_i=1 while data_valid_o=1 clears data_valid_o, frame_err_o, break_o and overrun_o on the next edge, unless a completion loads in the same cycle. In that case the new character wins: valid stays 1, flags take the new values, overrun_o clears.
- data_ack_i while data_valid_o=0 has no effect.
- Reset mid-frame discards the partial character without raising any flag.

Decomposition:
- Shared package irda_pkg: state encodings (ST_IDLE=2'd0, ST_DATA=2'd1, ST_STOP=2'd2) and the default DATA_BITS constant.
- Optional sub-module irda_rx_hold_reg: the holding register with valid/ack/overrun logic, reusable by the MIR/FIR receive paths.
- Deframer FSM and shifter stay in the top module.

Test Plan:
- 0xA5 frame: rx_zero_i sequence 1, then 0,1,0,1,1,0,1,0, then stop 0, one strobe every 16 clk -> one clk after the stop strobe data_o=0xA5, data_valid_o=1, frame_err_o=0, break_o=0; ack clears valid.
- Stop bit logical 0 with data 0x3C -> data_o=0x3C, frame_err_o=1, break_o=0. All-pulse frame (10 strobes with rx_zero_i=1) -> data_o=0x00, frame_err_o=1, break_o=1.
- Two frames 0x11 then 0x22, no ack -> data_o stays 0x11 and overrun_o=1. Ack in the same cycle as the 0x22 completion instead -> data_o=0x22, valid=1, overrun_o=0.
- fast_mode pulsed high after 4 data bits, then a full 0x5A frame -> data_o=0x5A, no error flags. wb_rst_n low for one clk mid-frame behaves identically and all outputs read 0.
- tx_select=1 during 3 strobes inside a 0xC3 frame (rx_zero_i toggling) -> those strobes are ignored and the frame completes correctly as 0xC3 after tx_select drops.
- DATA_BITS=5, frame carrying 0x15 -> data_o=5'h15 after 7 strobes (start, 5 data, stop).

Source files
------------

// File: rtl/irda_pkg.sv
// rtl/irda_pkg.sv - shared state encodings and defaults for the IrDA receive path
package irda_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_STOP = 2'd2
  } rx_state_t;

  localparam int DEFAULT_DATA_BITS = 8;

endpackage

// File: rtl/irda_rx_hold_reg.sv
// rtl/irda_rx_hold_reg.sv - single-entry received-character holding register with valid/ack/overrun
module irda_rx_hold_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         wb_rst_n,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         load_frame_err,
  input  logic         load_brk,
  input  logic         ack,
  output logic [W-1:0] data,
  output logic         valid,
  output logic         frame_err,
  output logic         brk,
  output logic         overrun
);

  logic ack_eff;
  assign ack_eff = ack & valid;

  always_ff @(posedge clk) begin
    if (!wb_rst_n) begin
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      brk       <= 1'b0;
      overrun   <= 1'b0;
    end else if (load && (!valid || ack_eff)) begin
      // a character being acked in the same cycle frees the slot for the new one
      data      <= load_data;
      valid     <= 1'b1;
      frame_err <= load_frame_err;
      brk       <= load_brk;
      overrun   <= 1'b0;
    end else if (load) begin
      overrun <= 1'b1;
    end else if (ack_eff) begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
      brk       <= 1'b0;
      overrun   <= 1'b0;
    end
  end

endmodule

// File: rtl/irda_sir_rx_deframer.sv
// rtl/irda_sir_rx_deframer.sv - recovers async start/data/stop characters from decoded SIR bits
module irda_sir_rx_deframer
  import irda_pkg::*;
#(
  parameter int DATA_BITS = DEFAULT_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 wb_rst_n,
  input  logic                 fast_mode,
  input  logic                 tx_select,
  input  logic                 bit_stb_i,
  input  logic                 rx_zero_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 data_valid_o,
  input  logic                 data_ack_i,
  output logic                 frame_err_o,
  output logic                 break_o,
  output logic                 overrun_o
);

  localparam int CNT_W = $clog2(DATA_BITS);

  rx_state_t            state, state_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic [DATA_BITS-1:0] shreg, shreg_nxt;
  logic                 qual;
  logic                 bit_val;
  logic                 done;

  assign qual    = bit_stb_i & ~tx_select & ~fast_mode;
  assign bit_val = ~rx_zero_i;

  always_ff @(posedge clk) begin
    if (!wb_rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      shreg <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      shreg <= shreg_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    shreg_nxt = shreg;
    done      = 1'b0;
    if (fast_mode) begin
      state_nxt = ST_IDLE;
      cnt_nxt   = '0;
      shreg_nxt = '0;
    end else if (qual) begin
      case (state)
        ST_IDLE: begin
          if (!bit_val) begin
            state_nxt = ST_DATA;
            cnt_nxt   = '0;
          end
        end
        ST_DATA: begin
          // line order is LSB first, so shifting right leaves the character aligned
          shreg_nxt = {bit_val, shreg[DATA_BITS-1:1]};
          cnt_nxt   = cnt + CNT_W'(1);
          if (cnt == CNT_W'(DATA_BITS - 1)) state_nxt = ST_STOP;
        end
        ST_STOP: begin
          // a logical-0 stop bit is consumed here, never treated as the next start bit
          done      = 1'b1;
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  irda_rx_hold_reg #(
    .W(DATA_BITS)
  ) u_hold (
    .clk           (clk),
    .wb_rst_n      (wb_rst_n),
    .load          (done),
    .load_data     (shreg),
    .load_frame_err(~bit_val),
    .load_brk      (~bit_val & (shreg == '0)),
    .ack           (data_ack_i),
    .data          (data_o),
    .valid         (data_valid_o),
    .frame_err     (frame_err_o),
    .brk           (break_o),
    .overrun       (overrun_o)
  );

endmodule

// File: tb/tb_irda_sir_rx_deframer.sv
// tb/tb_irda_sir_rx_deframer.sv - self-checking bench for irda_sir_rx_deframer
module tb_irda_sir_rx_deframer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, fast_mode, tx_select, stb, rz, ack, sel5;
  logic stb8, stb5, ack8, ack5;
  logic [7:0] d8;
  logic v8, fe8, br8, ov8;
  logic [4:0] d5;
  logic v5, fe5, br5, ov5;

  assign stb8 = stb & ~sel5;
  assign stb5 = stb & sel5;
  assign ack8 = ack & ~sel5;
  assign ack5 = ack & sel5;

  irda_sir_rx_deframer #(.DATA_BITS(8)) dut (
    .clk(clk), .wb_rst_n(rst_n), .fast_mode(fast_mode), .tx_select(tx_select),
    .bit_stb_i(stb8), .rx_zero_i(rz), .data_o(d8), .data_valid_o(v8),
    .data_ack_i(ack8), .frame_err_o(fe8), .break_o(br8), .overrun_o(ov8)
  );

  irda_sir_rx_deframer #(.DATA_BITS(5)) dut5 (
    .clk(clk), .wb_rst_n(rst_n), .fast_mode(fast_mode), .tx_select(tx_select),
    .bit_stb_i(stb5), .rx_zero_i(rz), .data_o(d5), .data_valid_o(v5),
    .data_ack_i(ack5), .frame_err_o(fe5), .break_o(br5), .overrun_o(ov5)
  );

  int n_checks = 0;
  int n_fail = 0;

  // reference: what the consumer should currently see in the holding register
  logic [7:0] m_data;
  logic m_valid, m_fe, m_brk, m_ovr;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic [7:0] exp_data;
    logic       exp_fe;
    logic       exp_brk;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_data = 8'h00; m_valid = 1'b0; m_fe = 1'b0; m_brk = 1'b0; m_ovr = 1'b0;
  endtask

  task automatic model_complete(input logic [7:0] d, input logic stop, input logic ack_same);
    if (!m_valid || ack_same) begin
      m_data  = d;
      m_valid = 1'b1;
      m_fe    = !stop;
      m_brk   = !stop && (d == 8'h00);
      m_ovr   = 1'b0;
    end else begin
      m_ovr = 1'b1;
    end
  endtask

  task automatic model_ack();
    if (m_valid) begin
      m_valid = 1'b0; m_fe = 1'b0; m_brk = 1'b0; m_ovr = 1'b0;
    end
  endtask

  task automatic check_outputs(input string name);
    check({name, "_data"}, 32'(d8), 32'(m_data));
    check({name, "_valid"}, 32'(v8), 32'(m_valid));
    check({name, "_fe"}, 32'(fe8), 32'(m_fe));
    check({name, "_brk"}, 32'(br8), 32'(m_brk));
    check({name, "_ovr"}, 32'(ov8), 32'(m_ovr));
  endtask

  task automatic gap(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic strobe(input logic z, input logic ack_now);
    @(negedge clk);
    stb = 1'b1; rz = z; ack = ack_now;
    @(negedge clk);
    stb = 1'b0; ack = 1'b0;
  endtask

  task automatic do_ack();
    @(negedge clk); ack = 1'b1;
    @(negedge clk); ack = 1'b0;
  endtask

  // returns one clk after the stop strobe so completion can be checked immediately
  task automatic send_frame(input logic [7:0] d, input logic stop, input int nb,
                            input logic ack_stop, input int g, input int tx_at);
    strobe(1'b1, 1'b0); gap(g);
    for (int i = 0; i < nb; i++) begin
      if (i == tx_at) begin
        tx_select = 1'b1;
        for (int j = 0; j < 3; j++) begin
          strobe(j[0], 1'b0); gap(g);
        end
        tx_select = 1'b0;
      end
      strobe(!d[i], 1'b0); gap(g);
    end
    strobe(!stop, ack_stop);
  endtask

  task automatic partial4();
    strobe(1'b1, 1'b0); gap(15);
    for (int i = 0; i < 4; i++) begin
      strobe(i[0], 1'b0); gap(15);
    end
  endtask

  initial begin
    rst_n = 1'b0; fast_mode = 1'b0; tx_select = 1'b0;
    stb = 1'b0; rz = 1'b0; ack = 1'b0; sel5 = 1'b0;
    model_reset();
    gap(3);
    rst_n = 1'b1;
    gap(1);
    check_outputs("reset");
    check("reset_d5", 32'({d5, v5, fe5, br5, ov5}), 32'h0);

    sel5 = 1'b1;
    send_frame(8'h15, 1'b1, 5, 1'b0, 15, -1);
    check("db5_data", 32'(d5), 32'h15);
    check("db5_valid", 32'(v5), 32'h1);
    check("db5_flags", 32'({fe5, br5, ov5}), 32'h0);
    gap(15);
    sel5 = 1'b0;

    vecs[0] = '{8'hA5, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{8'h3C, 1'b0, 8'h3C, 1'b1, 1'b0};
    vecs[2] = '{8'h00, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[3] = '{8'h00, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[4] = '{8'hFF, 1'b1, 8'hFF, 1'b0, 1'b0};
    vecs[5] = '{8'h80, 1'b0, 8'h80, 1'b1, 1'b0};
    for (int k = 0; k < 6; k++) begin
      send_frame(vecs[k].data, vecs[k].stop, 8, 1'b0, 15, -1);
      model_complete(vecs[k].data, vecs[k].stop, 1'b0);
      check("vec_data", 32'(d8), 32'(vecs[k].exp_data));
      check("vec_valid", 32'(v8), 32'h1);
      check("vec_fe", 32'(fe8), 32'(vecs[k].exp_fe));
      check("vec_brk", 32'(br8), 32'(vecs[k].exp_brk));
      gap(15);
      do_ack(); model_ack();
      check("vec_ack_valid", 32'({v8, fe8, br8, ov8}), 32'h0);
    end

    send_frame(8'h11, 1'b1, 8, 1'b0, 15, -1); model_complete(8'h11, 1'b1, 1'b0);
    gap(15);
    send_frame(8'h22, 1'b1, 8, 1'b0, 15, -1); model_complete(8'h22, 1'b1, 1'b0);
    check("ovr_data", 32'(d8), 32'h11);
    check("ovr_flag", 32'(ov8), 32'h1);
    check_outputs("ovr");
    do_ack(); model_ack();
    check_outputs("ovr_ack");

    send_frame(8'h11, 1'b1, 8, 1'b0, 15, -1); model_complete(8'h11, 1'b1, 1'b0);
    gap(15);
    send_frame(8'h22, 1'b1, 8, 1'b1, 15, -1); model_complete(8'h22, 1'b1, 1'b1);
    check("acksame_data", 32'(d8), 32'h22);
    check("acksame_valid", 32'(v8), 32'h1);
    check("acksame_ovr", 32'(ov8), 32'h0);
    do_ack(); model_ack();

    send_frame(8'hC3, 1'b1, 8, 1'b0, 15, 3); model_complete(8'hC3, 1'b1, 1'b0);
    check("txsel_data", 32'(d8), 32'hC3);
    check_outputs("txsel");
    do_ack(); model_ack();

    send_frame(8'h3C, 1'b1, 8, 1'b0, 15, -1); model_complete(8'h3C, 1'b1, 1'b0);
    partial4();
    @(negedge clk); fast_mode = 1'b1;
    @(negedge clk); fast_mode = 1'b0;
    check_outputs("fast_hold");
    do_ack(); model_ack();
    send_frame(8'h5A, 1'b1, 8, 1'b0, 15, -1); model_complete(8'h5A, 1'b1, 1'b0);
    check("fast_data", 32'(d8), 32'h5A);
    check("fast_flags", 32'({fe8, br8, ov8}), 32'h0);
    do_ack(); model_ack();

    send_frame(8'h3C, 1'b1, 8, 1'b0, 15, -1); model_complete(8'h3C, 1'b1, 1'b0);
    partial4();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    model_reset();
    check_outputs("rst_mid");
    send_frame(8'h5A, 1'b1, 8, 1'b0, 15, -1); model_complete(8'h5A, 1'b1, 1'b0);
    check("rst_data", 32'(d8), 32'h5A);
    check("rst_flags", 32'({fe8, br8, ov8}), 32'h0);
    do_ack(); model_ack();

    do_ack(); model_ack();
    check_outputs("idle_ack");

    for (int k = 0; k < 40; k++) begin
      logic [7:0] d;
      logic s, a_same;
      int g, tx_at;
      d      = 8'($urandom);
      if ($urandom_range(0, 5) == 0) d = 8'h00;
      s      = ($urandom_range(0, 3) != 0);
      a_same = ($urandom_range(0, 3) == 0);
      g      = $urandom_range(0, 4);
      tx_at  = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 7) : -1;
      send_frame(d, s, 8, a_same, g, tx_at);
      model_complete(d, s, a_same);
      check_outputs("rand");
      if ($urandom_range(0, 1) == 1) begin
        do_ack(); model_ack();
        check_outputs("rand_ack");
      end
      gap(g);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
